hidden_layer_accumulator: RTL
=============================

Name: hidden_layer_accumulator

Overview:
- Downstream consumer of the input layer's active-pixel index queue.
- For each dequeued pixel index, reads one signed weight per hidden neuron from an external weight memory and adds it into that neuron's accumulator.
- When the queue drains, streams the NUM_NEURONS sums out over a valid/ready handshake, pulses frameDone, and returns to idle.

Parameters:
- NUM_NEURONS, 16: hidden neurons, i.e. accumulators; power of two.
- INDEX_WIDTH, 10: width of the pixel index from the input queue.
- WEIGHT_WIDTH, 8: signed two's-complement weight width.
- ACC_WIDTH, 18: signed accumulator width.
- ADDR_WIDTH, 14: weight memory address width, at least INDEX_WIDTH+log2(NUM_NEURONS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- frameStart  in  1  one-cycle pulse: the upstream queue holds a complete frame.
- queueEmpty  in  1  upstream queue empty.
- indexIn  in  INDEX_WIDTH  head-of-queue pixel index; valid while queueEmpty=0.
- dequeue  out  1  one-cycle pop strobe to the upstream queue.
- weightAddr  out  ADDR_WIDTH  weight memory address = index*NUM_NEURONS + neuron.
- weightRead  out  1  read enable; weightData is valid exactly one cycle later.
- weightData  in  WEIGHT_WIDTH  signed weight.
- sumValid  out  1  sumOut/sumIndex valid.
- sumReady  in  1  downstream accepts the current sum.
- sumOut  out  ACC_WIDTH  signed neuron sum.
- sumIndex  out  log2(NUM_NEURONS)  neuron number of sumOut.
- frameDone  out  1  one-cycle pulse after the last sum is accepted.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; set when frameStart arrives while busy=1.

Behaviour:
- Reset (reset=0, async):
  - State to IDLE; all accumulators and counters to 0.
  - dequeue, weightRead, sumValid, frameDone, busy and overrun all 0; weightAddr, sumOut and sumIndex all 0.
- States: IDLE, POP, READ, DRAIN, EMIT, DONE.
- IDLE:
  - Accumulators hold 0.
  - On frameStart=1, go to POP.
- POP (1 cycle):
  - If queueEmpty=0: dequeue=1, latch indexIn into pixelReg, clear neuron counter n, go to READ.
  - If queueEmpty=1: dequeue=0, go to EMIT with k=0.
- READ (NUM_NEURONS cycles):
  - Each cycle: weightRead=1, weightAddr={pixelReg, n}, then n++.
  - Data for address n arrives one cycle later and is added into acc[n].
  - After n=NUM_NEURONS-1, go to DRAIN.
- DRAIN (1 cycle):
  - Absorb the last weight into acc[NUM_NEURONS-1]; weightRead=0; go to POP.
- Per-pixel cost: exactly NUM_NEURONS+2 cycles.
- Accumulation:
  - Weight is sign-extended to ACC_WIDTH and added with saturation.
  - Clamp at +(2^(ACC_WIDTH-1)-1) and at -2^(ACC_WIDTH-1); never wrap.
  - Defaults (784*127 < 2^17) cannot saturate.
- EMIT:
  - sumValid=1, sumOut=acc[k], sumIndex=k.
  - Outputs stay stable while sumReady=0.
  - On sumValid&sumReady: k++; after k=NUM_NEURONS-1 is accepted, go to DONE.
- DONE (1 cycle):
  - frameDone=1; clear all accumulators; go to IDLE.
  - The next frameStart is accepted from the following cycle.
- Pulse rules:
  - dequeue is never high on two consecutive cycles.
  - dequeue is never high while queueEmpty=1.
- frameStart when busy=1: ignored for control purposes; sets overrun.
- Upstream changes to queueEmpty/indexIn outside POP are ignored.
- Reset asserted mid-frame: abort immediately; no further dequeue or weightRead; no frameDone.

Test Plan:
- Weight model w[a]=(a mod 16)+1; queue holds 0, 5, 783; pulse frameStart.
  - Required: exactly 3 dequeue pulses, each followed by 16 reads.
  - Required: sums 3,6,...,48 for neurons 0..15; frameDone pulses once.
  - Required: first sumValid 3*18+1 cycles after the POP cycle.
- Empty queue at frameStart.
  - Required: no dequeue, no weightRead; 16 sums of 0 emitted; frameDone pulses.
- Backpressure: hold sumReady=0 for 5 cycles at k=3, then toggle it every cycle.
  - Required: sumOut/sumIndex stable while stalled; every sum delivered exactly once, in order.
- ACC_WIDTH=8, weights all +127, 3 pixels.
  - Required: every sum is 127.
  - Repeat with weights -128: every sum is -128.
- frameStart pulsed during READ.
  - Required: overrun=1 and stays set; current frame result unaffected; overrun cleared only by reset.
- Drive reset=0 mid-READ of the second pixel, release it, then run a fresh 1-pixel frame with index 2.
  - Required: busy=0 immediately on reset; no frameDone from the aborted frame.
  - Required: new sums equal w[32+n], with no residue from the aborted frame.

Source files
------------

// File: rtl/hidden_layer_accumulator.sv
// Hidden-layer accumulator: pops active pixel indices, sums one signed weight per
// neuron into saturating accumulators, then streams the neuron sums downstream.
//
// state | meaning
// IDLE  | waiting for frameStart, accumulators hold 0
// POP   | pop the next pixel index, or move to EMIT if the queue is empty
// READ  | issue NUM_NEURONS weight reads for the latched pixel
// DRAIN | absorb the final weight of the burst
// EMIT  | present acc[k] on the valid/ready output
// DONE  | pulse frameDone and clear the accumulators
module hidden_layer_accumulator #(
  parameter int NUM_NEURONS  = 16,
  parameter int INDEX_WIDTH  = 10,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 18,
  parameter int ADDR_WIDTH   = 14,
  localparam int NEURON_BITS = $clog2(NUM_NEURONS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frameStart,
  input  logic                    queueEmpty,
  input  logic [INDEX_WIDTH-1:0]  indexIn,
  output logic                    dequeue,
  output logic [ADDR_WIDTH-1:0]   weightAddr,
  output logic                    weightRead,
  input  logic [WEIGHT_WIDTH-1:0] weightData,
  output logic                    sumValid,
  input  logic                    sumReady,
  output logic [ACC_WIDTH-1:0]    sumOut,
  output logic [NEURON_BITS-1:0]  sumIndex,
  output logic                    frameDone,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [2:0] {IDLE, POP, READ, DRAIN, EMIT, DONE} stateT;

  localparam logic [NEURON_BITS-1:0] LAST = NEURON_BITS'(NUM_NEURONS - 1);

  stateT                   state, stateNext;
  logic [INDEX_WIDTH-1:0]  pixelReg;
  logic [NEURON_BITS-1:0]  n, k, pendIdx;
  logic                    pending;
  logic [ACC_WIDTH-1:0]    acc [NUM_NEURONS];
  logic [ACC_WIDTH:0]      accExt, weightExt, sumWide;
  logic [ACC_WIDTH-1:0]    accSat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (frameStart) stateNext = POP;
      POP:     stateNext = queueEmpty ? EMIT : READ;
      READ:    if (n == LAST) stateNext = DRAIN;
      DRAIN:   stateNext = POP;
      EMIT:    if (sumReady && k == LAST) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixelReg <= '0;
      n        <= '0;
      k        <= '0;
      pendIdx  <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (state == POP) begin
        k <= '0;
        if (!queueEmpty) begin
          pixelReg <= indexIn;
          n        <= '0;
        end
      end
      if (state == READ) n <= n + NEURON_BITS'(1);
      if (state == EMIT && sumReady) k <= k + NEURON_BITS'(1);
      // Read data returns one cycle after the address, so tag it with the neuron.
      pending <= (state == READ);
      pendIdx <= n;
      if (frameStart && state != IDLE) overrun <= 1'b1;
    end
  end

  always_comb begin
    accExt    = {acc[pendIdx][ACC_WIDTH-1], acc[pendIdx]};
    weightExt = {{(ACC_WIDTH + 1 - WEIGHT_WIDTH){weightData[WEIGHT_WIDTH-1]}}, weightData};
    sumWide   = accExt + weightExt;
    accSat    = sumWide[ACC_WIDTH-1:0];
    if (sumWide[ACC_WIDTH] != sumWide[ACC_WIDTH-1])
      accSat = sumWide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) acc[i] <= '0;
    end else if (state == DONE) begin
      for (int i = 0; i < NUM_NEURONS; i++) acc[i] <= '0;
    end else if (pending) begin
      acc[pendIdx] <= accSat;
    end
  end

  assign dequeue    = (state == POP) && !queueEmpty;
  assign weightRead = (state == READ);
  assign weightAddr = weightRead ? ADDR_WIDTH'({pixelReg, n}) : '0;
  assign sumValid   = (state == EMIT);
  assign sumOut     = sumValid ? acc[k] : '0;
  assign sumIndex   = k;
  assign frameDone  = (state == DONE);
  assign busy       = (state != IDLE);

endmodule
